// File: rtl/lpif_dstrm_rr_arb.sv
// Round-robin arbiter sharing one LPIF downstream flit channel among up to four stacks.
// Bursts are capped at MAX_BURST flits; the winner's index is stamped on dstrm_protid.
module lpif_dstrm_rr_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned MAX_BURST  = 8
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3:0]                    lnk_state,
  input  logic                          dstrm_ready,
  output logic [3:0]                    dstrm_state,
  output logic [1:0]                    dstrm_protid,
  output logic [DATA_WIDTH-1:0]         dstrm_data,
  output logic                          dstrm_dvalid,
  output logic [3:0]                    dstrm_crc,
  output logic                          dstrm_crc_valid,
  output logic                          dstrm_valid,
  output logic                          arb_busy
);

  localparam int unsigned BCW        = $clog2(MAX_BURST) + 1;
  localparam logic [3:0]  LNK_ACTIVE = 4'h1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              grant, rr_ptr, sel, grant_inc;
  logic                    sel_found;
  logic [BCW-1:0]          burst_cnt;
  logic                    out_full;
  logic [DATA_WIDTH-1:0]   out_data;
  logic [1:0]              out_protid;
  logic                    g_valid, g_last;
  logic [DATA_WIDTH-1:0]   g_data;
  logic                    slot_free, accept, burst_end;

  // Search order starts at rr_ptr and wraps; offset-major loop keeps indices constant.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && req_valid[i] && (((32'(rr_ptr) + k) % NUM_REQ) == i)) begin
          sel_found = 1'b1;
          sel       = 2'(i);
        end
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == 2'(i)) begin
        g_valid = req_valid[i];
        g_last  = req_last[i];
        g_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_inc = (grant == 2'(NUM_REQ - 1)) ? '0 : grant + 2'd1;
  assign slot_free = ~out_full | dstrm_ready;

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        if (lnk_state == LNK_ACTIVE && sel_found) state_nxt = BURST;
      end
      BURST: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (grant == 2'(i)) req_ready[i] = slot_free;
        end
        accept    = g_valid & slot_free;
        burst_end = accept & (g_last | (burst_cnt == BCW'(MAX_BURST - 1)));
        if (burst_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BURST) begin
        grant     <= sel;
        burst_cnt <= '0;
      end
      if (accept)    burst_cnt <= burst_cnt + BCW'(1);
      if (burst_end) rr_ptr    <= grant_inc;
    end
  end

  // Output slot: a new accept overwrites the slot only when it is empty or draining.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      out_full    <= 1'b0;
      out_data    <= '0;
      out_protid  <= '0;
      dstrm_state <= '0;
      dstrm_valid <= 1'b0;
    end else begin
      dstrm_state <= lnk_state;
      dstrm_valid <= 1'b1;
      if (accept) begin
        out_full   <= 1'b1;
        out_data   <= g_data;
        out_protid <= grant;
      end else if (dstrm_ready) begin
        out_full <= 1'b0;
      end
    end
  end

  assign dstrm_dvalid    = out_full;
  assign dstrm_data      = out_data;
  assign dstrm_protid    = out_protid;
  assign dstrm_crc       = 4'h0;
  assign dstrm_crc_valid = 1'b0;
  assign arb_busy        = (state == BURST);

endmodule
